pci_beat_packer: RTL and testbench

//  Upstream feeder of the PE PCI input port (i_valid_pci/i_data_pci/o_ready_pci).

---
 rtl/pci_beat_packer_pkg.sv | 22 ++
 rtl/pci_beat_packer_if.sv | 25 ++
 rtl/pci_beat_fifo.sv | 82 ++++++++
 rtl/pci_beat_packer.sv | 85 ++++++++
 tb/tb_pci_beat_packer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pci_beat_packer_pkg.sv
// Shared widths, lane/count types and the FIFO entry layout for the PCI beat packer.
package pci_pack_pkg;

  localparam int IN_W  = 64;
  localparam int OUT_W = 256;
  localparam int RATIO = OUT_W / IN_W;
  localparam int CNT_W = $clog2(RATIO + 1);

  typedef logic [CNT_W-1:0] lane_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
    lane_t            cnt;
  } beat_t;

  // True when the given lane is the final lane of a beat.
  function automatic logic is_last_lane(input lane_t lane);
    return (lane == lane_t'(RATIO - 1));
  endfunction

endpackage

// File: rtl/pci_beat_packer_if.sv
// Host word stream in, packed PE PCI beat stream out.
interface pci_beat_packer_if;
  import pci_pack_pkg::*;

  logic             i_valid;
  logic [IN_W-1:0]  i_data;
  logic             i_last;
  logic             o_ready;
  logic [OUT_W-1:0] o_data_pci;
  logic             o_valid_pci;
  logic             o_last_pci;
  lane_t            o_word_cnt;
  logic             i_ready_pci;

  modport master (
    output i_valid, i_data, i_last, i_ready_pci,
    input  o_ready, o_data_pci, o_valid_pci, o_last_pci, o_word_cnt
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready_pci,
    output o_ready, o_data_pci, o_valid_pci, o_last_pci, o_word_cnt
  );

endinterface

// File: rtl/pci_beat_fifo.sv
// Two-entry beat FIFO; the head entry, flags and count all come straight from registers.
module pci_beat_fifo
  import pci_pack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  beat_t      i_din,
  input  logic       i_pop,
  output beat_t      o_dout,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);

  beat_t      r_ent0;
  beat_t      r_ent1;
  logic [1:0] r_count;
  logic       r_full;
  logic       r_empty;

  beat_t      w_ent0_nxt;
  beat_t      w_ent1_nxt;
  logic [1:0] w_count_nxt;
  logic       w_push;
  logic       w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Head always sits in r_ent0; a pop shifts r_ent1 forward.
  always_comb begin
    w_ent0_nxt  = r_ent0;
    w_ent1_nxt  = r_ent1;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10: begin
        if (r_count == 2'd0) begin
          w_ent0_nxt = i_din;
        end else begin
          w_ent1_nxt = i_din;
        end
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        w_ent0_nxt  = r_ent1;
        w_ent1_nxt  = '0;
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        // Only reachable at count 1: the new beat replaces the departing head.
        w_ent0_nxt = i_din;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  // Storage, count and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_ent0  <= w_ent0_nxt;
      r_ent1  <= w_ent1_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == 2'd2);
      r_empty <= (w_count_nxt == 2'd0);
    end
  end

  assign o_dout  = r_ent0;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/pci_beat_packer.sv
// Packs IN_W-bit host words into OUT_W-bit PE beats, flushing zero-padded partial beats on i_last.
module pci_beat_packer
  import pci_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pci_beat_packer_if.slave  bus
);

  lane_t            r_lane;
  logic [OUT_W-1:0] r_asm;

  logic             w_ready;
  logic             w_accept;
  logic             w_complete;
  logic             w_push;
  logic [OUT_W-1:0] w_merged;
  beat_t            w_beat;
  beat_t            w_dout;
  logic             w_full;
  logic             w_empty;
  logic [1:0]       w_count;

  // Deliberately conservative: a full FIFO stalls even words that would not complete a beat.
  assign w_ready    = !rst && (w_count < 2'd2);
  assign w_accept   = bus.i_valid && w_ready;
  assign w_complete = w_accept && (is_last_lane(r_lane) || bus.i_last);
  assign w_push     = w_complete && !w_full;

  // Drop the current word into its lane of the assembly image.
  always_comb begin
    w_merged = r_asm;
    for (int k = 0; k < RATIO; k++) begin
      if (r_lane == lane_t'(k)) begin
        w_merged[k*IN_W +: IN_W] = bus.i_data;
      end else begin
        w_merged[k*IN_W +: IN_W] = r_asm[k*IN_W +: IN_W];
      end
    end
  end

  // Entry pushed on completion.
  always_comb begin
    w_beat      = '0;
    w_beat.data = w_merged;
    w_beat.last = bus.i_last;
    w_beat.cnt  = r_lane + lane_t'(1);
  end

  // Lane counter and assembly register; cleared whenever a beat leaves for the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= '0;
      r_asm  <= '0;
    end else if (w_complete) begin
      r_lane <= '0;
      r_asm  <= '0;
    end else if (w_accept) begin
      r_lane <= r_lane + lane_t'(1);
      r_asm  <= w_merged;
    end else begin
      r_lane <= r_lane;
      r_asm  <= r_asm;
    end
  end

  pci_beat_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_beat),
    .i_pop   (bus.i_ready_pci),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.o_ready     = w_ready;
  assign bus.o_valid_pci = !w_empty;
  assign bus.o_data_pci  = w_dout.data;
  assign bus.o_last_pci  = w_dout.last;
  assign bus.o_word_cnt  = w_dout.cnt;

endmodule

// File: tb/tb_pci_beat_packer.sv
// Directed bench for pci_beat_packer: packing, flush, backpressure, reset and same-cycle push/pop.
module tb_pci_beat_packer;
  import pci_pack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  pci_beat_packer_if bus ();

  pci_beat_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [OUT_W-1:0] data,
                          input int cnt, input logic last);
    chk({tag, "_valid"}, OUT_W'(bus.o_valid_pci), OUT_W'(1'b1));
    chk({tag, "_data"},  bus.o_data_pci, data);
    chk({tag, "_cnt"},   OUT_W'(bus.o_word_cnt), OUT_W'(cnt));
    chk({tag, "_last"},  OUT_W'(bus.o_last_pci), OUT_W'(last));
  endtask

  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic l);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0);
    bus.i_ready_pci = 1'b1;
    tick();
    tick();
    chk("rst_valid", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));
    chk("rst_last",  OUT_W'(bus.o_last_pci),  OUT_W'(1'b0));
    chk("rst_data",  bus.o_data_pci,          OUT_W'(1'b0));
    chk("rst_cnt",   OUT_W'(bus.o_word_cnt),  OUT_W'(1'b0));
    chk("rst_ready", OUT_W'(bus.o_ready),     OUT_W'(1'b0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", OUT_W'(bus.o_ready), OUT_W'(1'b1));

    // Two full beats, last on the 8th word.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 64'(k), (k == 8));
      tick();
      chk("t1_valid", OUT_W'(bus.o_valid_pci), OUT_W'((k == 4) || (k == 8)));
      if (k == 4) chk_beat("t1_beat0", {64'h4, 64'h3, 64'h2, 64'h1}, 4, 1'b0);
      if (k == 8) chk_beat("t1_beat1", {64'h8, 64'h7, 64'h6, 64'h5}, 4, 1'b1);
    end
    drive(1'b0, 64'h0, 1'b0);
    tick();
    chk("t1_drain", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));

    // Partial flush after 6 words.
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 64'(k), (k == 6));
      tick();
      if (k == 4) chk_beat("t2_beat0", {64'h4, 64'h3, 64'h2, 64'h1}, 4, 1'b0);
      if (k == 6) chk_beat("t2_beat1", {64'h0, 64'h0, 64'h6, 64'h5}, 2, 1'b1);
    end
    drive(1'b0, 64'h0, 1'b0);
    tick();
    chk("t2_drain", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));

    // Single-word beat also proves the lane counter returned to 0.
    drive(1'b1, 64'hA, 1'b1);
    tick();
    chk_beat("t3_single", {64'h0, 64'h0, 64'h0, 64'hA}, 1, 1'b1);
    drive(1'b0, 64'h0, 1'b0);
    tick();

    // Backpressure: two beats fill the FIFO, the 9th word must wait.
    bus.i_ready_pci = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 64'h21 + 64'(k), 1'b0);
      tick();
    end
    chk("t4_full_ready", OUT_W'(bus.o_ready), OUT_W'(1'b0));
    chk_beat("t4_hold0", {64'h24, 64'h23, 64'h22, 64'h21}, 4, 1'b0);
    drive(1'b1, 64'h29, 1'b0);
    tick();
    tick();
    chk("t4_still_stalled", OUT_W'(bus.o_ready), OUT_W'(1'b0));
    chk_beat("t4_hold1", {64'h24, 64'h23, 64'h22, 64'h21}, 4, 1'b0);
    bus.i_ready_pci = 1'b1;
    tick();
    chk_beat("t4_beatB", {64'h28, 64'h27, 64'h26, 64'h25}, 4, 1'b0);
    chk("t4_ready_back", OUT_W'(bus.o_ready), OUT_W'(1'b1));
    tick();
    chk("t4_gap", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));
    drive(1'b1, 64'h2A, 1'b0);
    tick();
    drive(1'b1, 64'h2B, 1'b0);
    tick();
    drive(1'b1, 64'h2C, 1'b1);
    tick();
    chk_beat("t4_beatC", {64'h2C, 64'h2B, 64'h2A, 64'h29}, 4, 1'b1);
    drive(1'b0, 64'h0, 1'b0);
    tick();
    chk("t4_drain", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));

    // Reset with a half-built beat in the assembly register.
    drive(1'b1, 64'h31, 1'b0);
    tick();
    drive(1'b1, 64'h32, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0);
    tick();
    chk("t5_rst_valid", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));
    chk("t5_rst_ready", OUT_W'(bus.o_ready), OUT_W'(1'b0));
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 64'h11 + 64'(k), (k == 3));
      tick();
      chk("t5_valid", OUT_W'(bus.o_valid_pci), OUT_W'(k == 3));
    end
    chk_beat("t5_beat", {64'h14, 64'h13, 64'h12, 64'h11}, 4, 1'b1);
    drive(1'b0, 64'h0, 1'b0);
    tick();
    chk("t5_drain", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));

    // Back-to-back one-word beats: push and pop together at count 1.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 64'h41 + 64'(k), 1'b1);
      tick();
      chk_beat("t6_pp", OUT_W'(64'h41 + 64'(k)), 1, 1'b1);
      chk("t6_ready", OUT_W'(bus.o_ready), OUT_W'(1'b1));
    end
    drive(1'b0, 64'h0, 1'b0);
    tick();
    chk("t6_drain", OUT_W'(bus.o_valid_pci), OUT_W'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
